mul32_wb_ctrl: RTL and testbench
================================

# mul32_wb_ctrl

Wishbone-slave sequencer for the 32x32 multiplier datapath inside `user_proj_mul32`. Software loads the operands, writes START, and the block hands the job to the multiplier with a one-cycle start pulse. It waits for `mul_done` (or a timeout), captures the 64-bit product and raises the user IRQ. It sits between the management-SoC Wishbone port and the multiplier core; `wbs_*` and `irq` pass straight through to `user_project_wrapper`.

## Interface
- BASE_ADDR, 32'h3000_0000: slave base address. Decode is on `wbs_adr_i[31:5] == BASE_ADDR[31:5]`.
- TIMEOUT_CYC, 64: maximum number of WAIT cycles before the job is aborted. 0 disables the timeout.
- wb_clk_i  in  1: the only clock.
- wb_rst_ni  in  1: asynchronous, active-low reset.
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each: Wishbone request.
- wbs_sel_i  in  4: byte enables for writes.
- wbs_adr_i, wbs_dat_i  in  32 each: address and write data.
- wbs_ack_o  out  1: single-cycle acknowledge.
- wbs_dat_o  out  32: read data, valid while ack is high, 0 otherwise.
- mul_start  out  1: one-cycle pulse that launches the datapath.
- mul_a, mul_b  out  32 each: operands, held stable from ISSUE through WAIT.
- mul_signed  out  1: selects two's-complement mode; held with the operands.
- mul_done  in  1: product valid pulse.
- mul_p  in  64: product, valid when `mul_done` is high.
- irq  out  3: `irq[0]` = IE & (DONE | ERR); `irq[2:1]` = 0.

## Operation
Register map (word offsets; `wbs_sel_i` applies to A and B):
- 0x00 A: rw.
- 0x04 B: rw.
- 0x08 CTRL/STATUS.
  - Write: bit0 START (write-1, self-clearing), bit1 SIGNED, bit2 IE, bit8 write-1-to-clear DONE, bit9 write-1-to-clear ERR.
  - Read: bit0 BUSY, bit1 SIGNED, bit2 IE, bit8 DONE, bit9 ERR.
- 0x0C P_LO: ro.
- 0x10 P_HI: ro.
- Offsets 0x14–0x1C: read 0, writes ignored, still acked.
- Address outside the decode window: no ack.

State machine:
- IDLE: a START write moves to ISSUE. The same write clears DONE and ERR.
- ISSUE: one cycle, `mul_start` = 1, then WAIT. The timeout counter is cleared.
- WAIT: on `mul_done`, P ← `mul_p`, DONE ← 1, go to IDLE. If the counter reaches TIMEOUT_CYC first, ERR ← 1, P unchanged, go to IDLE.
- BUSY = (state != IDLE).

Boundary rules:
- START write while BUSY: ignored, ERR ← 1, the job continues.
- A, B or SIGNED write while BUSY: ignored, ERR ← 1. IE writes are always accepted.
- W1C of DONE/ERR in the same cycle that hardware sets the flag: the set wins.
- `mul_done` in IDLE or ISSUE: ignored. A late `mul_done` after a timeout is discarded.
- A write with START=1 also applies SIGNED/IE from the same word before the launch.
- Reset mid-job: return to IDLE. Any outstanding datapath result is discarded.

Reset values: all registers 0, state IDLE, `wbs_ack_o` = 0, `wbs_dat_o` = 0, `mul_start` = 0, `mul_a`/`mul_b` = 0, `mul_signed` = 0, `irq` = 0.

## Timing
- Request seen in cycle k (`cyc & stb & !ack`, address decoded) → `wbs_ack_o` = 1 in cycle k+1 for exactly one cycle.
- A request still held in k+1 is not re-acked, so the fastest back-to-back rate is one access per 2 cycles.
- Register writes take effect at the k→k+1 edge.
- START write acked in cycle k+1 → ISSUE with `mul_start` high in cycle k+1 → WAIT from k+2.
- `mul_done` in cycle m (m ≥ k+2) → P, DONE, IDLE and `irq[0]` (if IE) all visible in cycle m+1.
- Timeout fires after TIMEOUT_CYC full WAIT cycles without `mul_done`; ERR is visible on the next cycle.
- All outputs are registered except `irq`, which is combinational from registers.

## Test plan
- Unsigned multiply: A=0xFFFF_FFFF, B=0x2, START; model returns done after 5 cycles → one `mul_start` pulse, P_LO=0xFFFF_FFFE, P_HI=0x1, DONE=1, BUSY=0.
- Signed multiply: SIGNED=1, A=0xFFFF_FFFE (−2), B=3 → `mul_signed`=1; model P=0xFFFF_FFFF_FFFF_FFFA read back exactly. IE=1 → `irq[0]`=1; W1C DONE → `irq[0]`=0.
- Busy protection: START, then write A=0x1234 and START again during WAIT → A and `mul_a` unchanged, no second `mul_start`, ERR=1, first job completes normally.
- Timeout: TIMEOUT_CYC=8, model never asserts done → ERR=1 in exactly 8 WAIT cycles after ISSUE, P unchanged, BUSY=0. A late `mul_done` leaves P unchanged.
- Bus protocol: hold stb for 4 cycles → exactly one ack. Offset 0x18 read → 0 with ack. Address BASE+0x100 → no ack. `wbs_sel_i`=4'b0001 write to A updates byte 0 only.
- Reset mid-WAIT: deassert `wb_rst_ni` asynchronously → all outputs 0 immediately. After release, a `mul_done` pulse does not set DONE.

Source files
------------

// File: rtl/mul32_wb_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mul32_wb_ctrl
//  Brief    : Wishbone-slave sequencer for the 32x32 multiplier datapath.
//             Holds operands, launches a job with a one-cycle start pulse,
//             captures the 64-bit product (or flags a timeout) and raises
//             the user IRQ.
//  Revision : 1.0 - initial release
// ============================================================================
module mul32_wb_ctrl #(
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int          TIMEOUT_CYC = 64
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        mul_start,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    output logic        mul_signed,
    input  logic        mul_done,
    input  logic [63:0] mul_p,
    output logic [2:0]  irq
);

    // Counter only has to reach TIMEOUT_CYC-1; keep at least one bit.
    localparam int c_CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [31:0]        r_a;
    logic [31:0]        r_b;
    logic               r_signed;
    logic               r_ie;
    logic               r_done;
    logic               r_err;
    logic [63:0]        r_p;
    logic               r_held;
    logic [31:0]        w_rdata;

    // ------------------------------------------------------------------
    // Bus decode. r_held blocks a second ack while the same strobe is
    // still asserted, so one held request yields exactly one ack.
    // ------------------------------------------------------------------
    logic       w_hit;
    logic       w_req;
    logic       w_wr;
    logic       w_rd;
    logic [2:0] w_off;
    logic       w_busy;
    logic       w_wr_a;
    logic       w_wr_b;
    logic       w_wr_ctrl;
    logic       w_launch;
    logic       w_job_done;
    logic       w_timeout;
    logic       w_busy_viol;
    logic       w_unused;

    assign w_hit     = (wbs_adr_i[31:5] == BASE_ADDR[31:5]);
    assign w_req     = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o & ~r_held & w_hit;
    assign w_wr      = w_req & wbs_we_i;
    assign w_rd      = w_req & ~wbs_we_i;
    assign w_off     = wbs_adr_i[4:2];
    assign w_busy    = (r_state != S_IDLE);
    assign w_wr_a    = w_wr & (w_off == 3'd0);
    assign w_wr_b    = w_wr & (w_off == 3'd1);
    assign w_wr_ctrl = w_wr & (w_off == 3'd2);
    assign w_unused  = &{1'b0, wbs_adr_i[1:0]};

    // A launch only happens from IDLE; a START while busy is an error.
    assign w_launch   = w_wr_ctrl & wbs_dat_i[0] & ~w_busy;
    assign w_job_done = (r_state == S_WAIT) & mul_done;
    assign w_timeout  = (r_state == S_WAIT) & ~mul_done & (TIMEOUT_CYC != 0)
                      & (r_cnt == c_CNT_LAST);
    // Touching operands/mode while a job runs is refused and flagged.
    // A CTRL write that leaves SIGNED unchanged only counts if it carries START.
    assign w_busy_viol = w_busy & (w_wr_a | w_wr_b |
                         (w_wr_ctrl & (wbs_dat_i[0] | (wbs_dat_i[1] != r_signed))));

    // Next-state logic of the job sequencer.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_launch) w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT:  if (w_job_done || w_timeout) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register, registered start pulse and WAIT-cycle counter.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state   <= S_IDLE;
            mul_start <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            mul_start <= (w_state_nxt == S_ISSUE);
            if (r_state != S_WAIT) r_cnt <= '0;
            else                   r_cnt <= r_cnt + 1'b1;
        end
    end

    // Software-visible registers: operands, mode, flags and product.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_a      <= '0;
            r_b      <= '0;
            r_signed <= 1'b0;
            r_ie     <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_p      <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_wr_a && !w_busy && wbs_sel_i[i]) r_a[8*i +: 8] <= wbs_dat_i[8*i +: 8];
                if (w_wr_b && !w_busy && wbs_sel_i[i]) r_b[8*i +: 8] <= wbs_dat_i[8*i +: 8];
            end
            if (w_wr_ctrl) r_ie <= wbs_dat_i[2];
            if (w_wr_ctrl && !w_busy) r_signed <= wbs_dat_i[1];

            // Hardware set takes priority over a simultaneous clear.
            if (w_job_done)                      r_done <= 1'b1;
            else if (w_launch)                   r_done <= 1'b0;
            else if (w_wr_ctrl && wbs_dat_i[8])  r_done <= 1'b0;

            if (w_timeout || w_busy_viol)        r_err <= 1'b1;
            else if (w_launch)                   r_err <= 1'b0;
            else if (w_wr_ctrl && wbs_dat_i[9])  r_err <= 1'b0;

            if (w_job_done) r_p <= mul_p;
        end
    end

    // Read-data multiplexer; unmapped offsets inside the window read 0.
    always_comb begin
        w_rdata = '0;
        case (w_off)
            3'd0:    w_rdata = r_a;
            3'd1:    w_rdata = r_b;
            3'd2:    w_rdata = {22'd0, r_err, r_done, 5'd0, r_ie, r_signed, w_busy};
            3'd3:    w_rdata = r_p[31:0];
            3'd4:    w_rdata = r_p[63:32];
            default: w_rdata = '0;
        endcase
    end

    // Registered single-cycle ack; read data is only non-zero with ack.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            r_held    <= 1'b0;
        end else begin
            wbs_ack_o <= w_req;
            wbs_dat_o <= w_rd ? w_rdata : 32'd0;
            r_held    <= (w_req | r_held) & wbs_cyc_i & wbs_stb_i;
        end
    end

    assign mul_a      = r_a;
    assign mul_b      = r_b;
    assign mul_signed = r_signed;
    assign irq        = {2'b00, r_ie & (r_done | r_err)};

endmodule
`default_nettype wire

// File: tb/tb_mul32_wb_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_mul32_wb_ctrl
//  Brief    : Self-checking bench for mul32_wb_ctrl with a latency-programmable
//             multiplier stand-in and a register-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mul32_wb_ctrl;

    localparam logic [31:0] c_BASE = 32'h3000_0000;
    localparam int          c_TMO  = 8;
    localparam logic [31:0] c_A    = c_BASE + 32'h00;
    localparam logic [31:0] c_B    = c_BASE + 32'h04;
    localparam logic [31:0] c_CTRL = c_BASE + 32'h08;
    localparam logic [31:0] c_PLO  = c_BASE + 32'h0C;
    localparam logic [31:0] c_PHI  = c_BASE + 32'h10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, wdat;
    logic        ack;
    logic [31:0] rdat;
    logic        mul_start;
    logic [31:0] mul_a, mul_b;
    logic        mul_signed;
    logic        mul_done = 1'b0;
    logic [63:0] mul_p = '0;
    logic [2:0]  irq;

    always #5 clk = ~clk;

    mul32_wb_ctrl #(.BASE_ADDR(c_BASE), .TIMEOUT_CYC(c_TMO)) u_dut (
        .wb_clk_i   (clk),
        .wb_rst_ni  (rst_n),
        .wbs_cyc_i  (cyc),
        .wbs_stb_i  (stb),
        .wbs_we_i   (we),
        .wbs_sel_i  (sel),
        .wbs_adr_i  (adr),
        .wbs_dat_i  (wdat),
        .wbs_ack_o  (ack),
        .wbs_dat_o  (rdat),
        .mul_start  (mul_start),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_signed (mul_signed),
        .mul_done   (mul_done),
        .mul_p      (mul_p),
        .irq        (irq)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Intended arithmetic: 64-bit product of two 32-bit operands.
    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic sg);
        longint sa, sb;
        if (sg) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    // Multiplier stand-in: done pulse mdl_lat cycles after mul_start
    // (0 = never answers); also serves manual injection requests.
    int          mdl_lat   = 5;
    int          start_cnt = 0;
    int          inj_req   = 0;
    int          inj_ack   = 0;
    logic [63:0] inj_p     = '0;
    logic        pend      = 1'b0;
    int          cd        = 0;
    logic [63:0] prod      = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            pend     <= 1'b0;
            mul_done <= 1'b0;
        end else begin
            mul_done <= 1'b0;
            if (inj_req != inj_ack) begin
                mul_done <= 1'b1;
                mul_p    <= inj_p;
                inj_ack  <= inj_req;
            end else if (pend) begin
                if (cd == 1) begin
                    mul_done <= 1'b1;
                    mul_p    <= prod;
                    pend     <= 1'b0;
                end
                cd <= cd - 1;
            end
            if (mul_start) begin
                start_cnt <= start_cnt + 1;
                if (mdl_lat != 0) begin
                    pend <= 1'b1;
                    cd   <= mdl_lat;
                    prod <= ref_mul(mul_a, mul_b, mul_signed);
                end
            end
        end
    end

    // Reference register state.
    logic [31:0] m_a, m_b;
    logic        m_sg, m_ie, m_done, m_err;
    logic [63:0] m_p;

    function automatic logic [31:0] exp_status();
        return {22'd0, m_err, m_done, 5'd0, m_ie, m_sg, 1'b0};
    endfunction

    // One Wishbone access; expects the ack on the first edge.
    task automatic wb_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [31:0] rd);
        if (ack) begin @(posedge clk); #1; end
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
        @(posedge clk); #1;
        check("ack", ack, 1);
        rd  = rdat;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] dummy;
        wb_access(1'b1, a, d, s, dummy);
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] rd);
        wb_access(1'b0, a, 32'd0, 4'hF, rd);
    endtask

    // Hold a request for four cycles and return the number of acks seen.
    task automatic hold_req(input logic [31:0] a, output int n);
        n = 0;
        if (ack) begin @(posedge clk); #1; end
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; sel = 4'hF;
        repeat (4) begin
            @(posedge clk); #1;
            if (ack) n++;
        end
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        int          sc, n;
        logic [31:0] ra, rb;
        logic        rsg, rie;
        int          lat;

        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
        adr = '0; wdat = '0;
        m_a = '0; m_b = '0; m_sg = 0; m_ie = 0; m_done = 0; m_err = 0; m_p = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        check("rst_ack", ack, 0);
        check("rst_dat", rdat, 0);
        check("rst_start", mul_start, 0);
        check("rst_mul_a", mul_a, 0);
        check("rst_mul_b", mul_b, 0);
        check("rst_signed", mul_signed, 0);
        check("rst_irq", irq, 0);
        wb_read(c_CTRL, rd); check("rst_status", rd, 0);
        wb_read(c_PLO, rd);  check("rst_plo", rd, 0);

        // Unsigned multiply
        mdl_lat = 5; sc = start_cnt;
        wb_write(c_A, 32'hFFFF_FFFF, 4'hF);
        wb_write(c_B, 32'h2, 4'hF);
        wb_write(c_CTRL, 32'h1, 4'hF);
        check("u_start_hi", mul_start, 1);
        @(posedge clk); #1;
        check("u_start_lo", mul_start, 0);
        repeat (10) @(posedge clk); #1;
        check("u_pulses", start_cnt - sc, 1);
        wb_read(c_PLO, rd);  check("u_plo", rd, 32'hFFFF_FFFE);
        wb_read(c_PHI, rd);  check("u_phi", rd, 32'h1);
        wb_read(c_CTRL, rd); check("u_status", rd, 32'h100);

        // Signed multiply with interrupt and exact done->irq latency
        mdl_lat = 3;
        wb_write(c_A, 32'hFFFF_FFFE, 4'hF);
        wb_write(c_B, 32'h3, 4'hF);
        wb_write(c_CTRL, 32'h7, 4'hF);
        check("s_signed", mul_signed, 1);
        check("s_irq_start", irq, 0);
        repeat (3) @(posedge clk); #1;
        check("s_irq_pre", irq[0], 0);
        @(posedge clk); #1;
        check("s_irq_done", irq, 3'b001);
        wb_read(c_PLO, rd);  check("s_plo", rd, 32'hFFFF_FFFA);
        wb_read(c_PHI, rd);  check("s_phi", rd, 32'hFFFF_FFFF);
        wb_read(c_CTRL, rd); check("s_status", rd, 32'h106);
        wb_write(c_CTRL, 32'h106, 4'hF);
        check("s_irq_w1c", irq[0], 0);
        wb_read(c_CTRL, rd); check("s_status_w1c", rd, 32'h006);

        // Busy protection
        mdl_lat = 7; sc = start_cnt;
        wb_write(c_A, 32'd5, 4'hF);
        wb_write(c_B, 32'd7, 4'hF);
        wb_write(c_CTRL, 32'h1, 4'hF);
        wb_write(c_A, 32'h1234, 4'hF);
        wb_read(c_CTRL, rd); check("b_status_busy", rd, 32'h201);
        wb_write(c_CTRL, 32'h1, 4'hF);
        check("b_mul_a", mul_a, 5);
        repeat (12) @(posedge clk); #1;
        check("b_pulses", start_cnt - sc, 1);
        wb_read(c_A, rd);    check("b_reg_a", rd, 5);
        wb_read(c_CTRL, rd); check("b_status", rd, 32'h300);
        wb_read(c_PLO, rd);  check("b_plo", rd, 35);
        wb_read(c_PHI, rd);  check("b_phi", rd, 0);

        // Timeout, then a late done that must be discarded
        mdl_lat = 0;
        wb_write(c_A, 32'd9, 4'hF);
        wb_write(c_B, 32'd9, 4'hF);
        wb_write(c_CTRL, 32'h5, 4'hF);
        repeat (c_TMO) @(posedge clk); #1;
        check("t_irq_pre", irq[0], 0);
        @(posedge clk); #1;
        check("t_irq_err", irq[0], 1);
        wb_read(c_CTRL, rd); check("t_status", rd, 32'h204);
        wb_read(c_PLO, rd);  check("t_plo", rd, 35);
        inj_p = 64'hDEAD_BEEF_0000_0001; inj_req++;
        repeat (4) @(posedge clk); #1;
        wb_read(c_PLO, rd);  check("t_late_plo", rd, 35);
        wb_read(c_CTRL, rd); check("t_late_status", rd, 32'h204);

        // Bus protocol
        hold_req(c_A, n);                  check("p_hold_acks", n, 1);
        wb_read(c_BASE + 32'h18, rd);      check("p_gap_read", rd, 0);
        hold_req(c_BASE + 32'h100, n);     check("p_outside_acks", n, 0);
        wb_write(c_A, 32'hAABB_CCDD, 4'hF);
        wb_write(c_A, 32'h1122_3344, 4'b0001);
        wb_read(c_A, rd);                  check("p_sel_reg", rd, 32'hAABB_CC44);
        check("p_sel_mul_a", mul_a, 32'hAABB_CC44);

        // Randomized jobs against the reference model
        m_p = 64'd35;
        for (int i = 0; i < 6; i++) begin
            ra  = $urandom;
            rb  = $urandom;
            rsg = 1'($urandom_range(0, 1));
            rie = 1'($urandom_range(0, 1));
            lat = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, c_TMO - 1))
                                              : int'($urandom_range(c_TMO + 2, c_TMO + 6));
            mdl_lat = lat; sc = start_cnt;
            wb_write(c_A, ra, 4'hF);
            wb_write(c_B, rb, 4'hF);
            wb_write(c_CTRL, {29'd0, rie, rsg, 1'b1}, 4'hF);
            m_a = ra; m_b = rb; m_sg = rsg; m_ie = rie; m_done = 1'b0; m_err = 1'b0;
            if (lat < c_TMO) begin
                m_p    = ref_mul(m_a, m_b, m_sg);
                m_done = 1'b1;
            end else begin
                m_err = 1'b1;
            end
            repeat (20) @(posedge clk); #1;
            check("r_pulses", start_cnt - sc, 1);
            check("r_irq", irq, {2'b00, m_ie & (m_done | m_err)});
            wb_read(c_CTRL, rd); check("r_status", rd, exp_status());
            wb_read(c_PLO, rd);  check("r_plo", rd, m_p[31:0]);
            wb_read(c_PHI, rd);  check("r_phi", rd, m_p[63:32]);
        end

        // Reset in the middle of WAIT
        mdl_lat = 0;
        wb_write(c_A, 32'd3, 4'hF);
        wb_write(c_B, 32'd4, 4'hF);
        wb_write(c_CTRL, 32'h7, 4'hF);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("x_mul_a", mul_a, 0);
        check("x_mul_b", mul_b, 0);
        check("x_ctl_outs", {ack, mul_start, mul_signed, irq}, 0);
        check("x_dat", rdat, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        inj_p = 64'h0123_4567_89AB_CDEF; inj_req++;
        repeat (4) @(posedge clk); #1;
        wb_read(c_CTRL, rd); check("x_status", rd, 0);
        wb_read(c_PLO, rd);  check("x_plo", rd, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
